sn76489_tone: RTL and testbench

Tone channel for the SN76489 sound generator; three instances sit directly downstream of `sn76489_latch_ctrl`, one per tone channel.
- Each instance consumes its channel's write strobe, the register-select bit (R2) and the CPU data byte.
- It holds the 10-bit frequency divider and the 4-bit attenuator, runs the down-counter that toggles the square-wave flip-flop, and drives an attenuated 8-bit level for the mixer.
- The channel-3 instance also exports its flip-flop to the noise generator.

---
 rtl/sn76489_pkg.sv | 21 ++
 rtl/sn76489_tone_if.sv | 16 +
 rtl/sn76489_attenuator.sv | 27 ++
 rtl/sn76489_tone.sv | 59 +++++
 tb/tb_sn76489_tone.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sn76489_pkg.sv
// Shared constants and types for the SN76489 tone and noise channels.
// The attenuator table and the register widths are common to every channel.
package sn76489_pkg;

    localparam int unsigned FREQ_W = 10;
    localparam int unsigned ATT_W  = 4;
    localparam int unsigned VOL_W  = 8;

    typedef logic [FREQ_W-1:0] freq_t;
    typedef logic [ATT_W-1:0]  att_t;
    typedef logic [VOL_W-1:0]  vol_t;

    localparam att_t ATT_MUTE = 4'hF;

    // 2 dB steps from 0 dB (255) down to mute; element [n] is the level for att = n.
    localparam logic [15:0][VOL_W-1:0] ATT_LUT = {
        8'd0,   8'd10,  8'd13,  8'd16,  8'd20,  8'd26,  8'd32,  8'd40,
        8'd51,  8'd64,  8'd81,  8'd102, 8'd128, 8'd161, 8'd203, 8'd255
    };

endpackage

// File: rtl/sn76489_tone_if.sv
// Channel-side bus of one tone channel: write strobe, register select, data byte
// in; square-wave flip-flop and attenuated level out.
interface sn76489_tone_if;
    import sn76489_pkg::*;

    logic       clk_en_i;
    logic       we_i;
    logic       r2_i;
    logic [0:7] d_i;
    logic       ff_o;
    vol_t       tone_o;

    modport master (output clk_en_i, we_i, r2_i, d_i, input ff_o, tone_o);
    modport slave  (input clk_en_i, we_i, r2_i, d_i, output ff_o, tone_o);

endinterface

// File: rtl/sn76489_attenuator.sv
// 4-bit attenuation register with its write decode and the level lookup.
// Shared by the tone and noise channels.
module sn76489_attenuator
    import sn76489_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  logic sel,
    input  att_t data,
    output vol_t vol
);

    att_t att;

    // Latch and data bytes both carry the attenuation in their low nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            att <= ATT_MUTE;
        end else if (we && sel) begin
            att <= data;
        end
    end

    assign vol = ATT_LUT[att];

endmodule

// File: rtl/sn76489_tone.sv
// SN76489 tone channel: 10-bit frequency register, reload down-counter driving
// the square-wave flip-flop, and attenuated output level.
module sn76489_tone
    import sn76489_pkg::*;
(
    input  logic           clock_i,
    input  logic           res_n_i,
    sn76489_tone_if.slave  bus
);

    logic  wr;
    freq_t freq;
    freq_t cnt;
    logic  ff;
    vol_t  vol;

    assign wr = bus.clk_en_i & bus.we_i;

    sn76489_attenuator u_att (
        .clk   (clock_i),
        .rst_n (res_n_i),
        .we    (wr),
        .sel   (bus.r2_i),
        .data  (bus.d_i[4:7]),
        .vol   (vol)
    );

    // Latch byte updates the low nibble, data byte the upper six bits.
    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            freq <= '0;
        end else if (wr && !bus.r2_i) begin
            if (bus.d_i[0]) begin
                freq[3:0] <= bus.d_i[4:7];
            end else begin
                freq[9:4] <= bus.d_i[2:7];
            end
        end
    end

    // Reload uses the register value present before any same-edge write.
    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            cnt <= '0;
            ff  <= 1'b0;
        end else if (bus.clk_en_i) begin
            if (cnt == '0) begin
                cnt <= freq - freq_t'(1);
                ff  <= ~ff;
            end else begin
                cnt <= cnt - freq_t'(1);
            end
        end
    end

    assign bus.ff_o   = ff;
    assign bus.tone_o = ff ? vol : '0;

endmodule

// File: tb/tb_sn76489_tone.sv
// Directed and randomized bench for sn76489_tone against a tick-count reference model.
module tb_sn76489_tone;

    logic clk;
    logic rst_n;

    sn76489_tone_if bus ();

    sn76489_tone dut (
        .clock_i (clk),
        .res_n_i (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] vol_tab [16] = '{8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
                                 8'd40,  8'd32,  8'd26,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0};

    // Reference: toggles happen at absolute tick numbers; each toggle schedules
    // the next one freq ticks later (1024 when freq is 0).
    int m_freq;
    int m_att;
    int tick;
    int next_toggle;
    bit m_ff;

    function automatic void model_reset();
        m_freq = 0;
        m_att = 15;
        tick = 0;
        next_toggle = 1;
        m_ff = 1'b0;
    endfunction

    function automatic void model_edge(input bit en, input bit we, input bit r2, input logic [7:0] b);
        if (en) begin
            tick++;
            if (tick == next_toggle) begin
                m_ff = !m_ff;
                next_toggle = tick + ((m_freq == 0) ? 1024 : m_freq);
            end
            if (we) begin
                if (r2) m_att = int'(b[3:0]);
                else if (b[7]) m_freq = (m_freq & 32'h3F0) | int'(b[3:0]);
                else m_freq = (m_freq & 32'h00F) | (int'(b[5:0]) << 4);
            end
        end
    endfunction

    function automatic logic [7:0] exp_tone();
        return m_ff ? vol_tab[m_att] : 8'd0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, tick);
        end
    endtask

    task automatic step(input bit en, input bit we, input bit r2, input logic [7:0] b);
        bus.clk_en_i = en;
        bus.we_i     = we;
        bus.r2_i     = r2;
        bus.d_i      = b;
        @(posedge clk);
        model_edge(en, we, r2, b);
        #1;
        check("ff", {7'b0, bus.ff_o}, {7'b0, m_ff});
        check("tone", bus.tone_o, exp_tone());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int guard;
        logic [7:0] b;
        bit en;
        bit we;
        bit r2;

        rst_n = 1'b0;
        bus.clk_en_i = 1'b0;
        bus.we_i = 1'b0;
        bus.r2_i = 1'b0;
        bus.d_i = 8'h00;
        model_reset();
        #1;
        check("reset_ff", {7'b0, bus.ff_o}, 8'h00);
        check("reset_tone", bus.tone_o, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two-byte frequency write 0x85/0x12 -> 0x125, full volume.
        step(1'b1, 1'b1, 1'b0, 8'h85);
        step(1'b1, 1'b1, 1'b0, 8'h12);
        step(1'b1, 1'b1, 1'b1, 8'h90);
        idle(1100 + 3 * 293);

        // freq = 0x155, then asynchronous reset while ff is high.
        step(1'b1, 1'b1, 1'b0, 8'h85);
        step(1'b1, 1'b1, 1'b0, 8'h15);
        idle(1100);
        guard = 0;
        while (!m_ff && guard < 400) begin
            idle(1);
            guard++;
        end
        check("pre_reset_ff_high", {7'b0, bus.ff_o}, 8'h01);
        idle(20);
        rst_n = 1'b0;
        #2;
        check("async_reset_ff", {7'b0, bus.ff_o}, 8'h00);
        check("async_reset_tone", bus.tone_o, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(1);
        check("first_tick_ff", {7'b0, bus.ff_o}, 8'h01);

        // Attenuation sweep while ff is high (freq = 0 keeps it high 1024 ticks).
        for (int a = 0; a < 16; a++) begin
            b = 8'h90 | 8'(a);
            step(1'b1, 1'b1, 1'b1, b);
        end
        check("sweep_muted", bus.tone_o, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h03);
        check("att3_data_byte", bus.tone_o, 8'd128);

        // freq = 0 boundary: toggles every 1024 ticks.
        idle(2100);

        // freq = 1 boundary: toggle every tick once reloaded.
        step(1'b1, 1'b1, 1'b0, 8'h81);
        idle(1100);

        // clk_en every 4th clock; writes on disabled clocks must be ignored.
        step(1'b1, 1'b1, 1'b0, 8'h83);
        for (int i = 0; i < 400; i++) begin
            en = (i % 4) == 0;
            b = 8'($urandom);
            step(en, !en, 1'($urandom), b);
        end

        // Collision: freq = 4, then write 8 on the reload edge.
        step(1'b1, 1'b1, 1'b0, 8'h84);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        idle(10);
        guard = 0;
        while (next_toggle != tick + 1 && guard < 3000) begin
            idle(1);
            guard++;
        end
        check("collision_align_bound", (guard < 3000) ? 8'h01 : 8'h00, 8'h01);
        step(1'b1, 1'b1, 1'b0, 8'h88);
        idle(40);

        // Held strobe: same latch byte for 6 enabled clocks.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'h8A);
        idle(60);

        // Randomized traffic; data-frequency bytes kept small so periods stay short.
        for (int i = 0; i < 600; i++) begin
            en = ($urandom % 4) != 0;
            we = ($urandom % 3) == 0;
            r2 = 1'($urandom);
            b = 8'($urandom);
            if (!r2 && !b[7]) b = b & 8'h01;
            step(en, we, r2, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
